// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 bit mux between four requesters.
// Grants one owner at a time, bounds burst length while others wait,
// and registers the selected data bit with a valid flag.
module mux_4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] I,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       Y,
  output logic       Y_valid
);

  localparam int unsigned N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [1:0]         s_d;

  logic [1:0]         win;
  logic               win_found;
  logic [1:0]         idx;
  logic               owner_req;
  logic               others_req;
  logic               hold_max;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    idx       = '0;
    for (int d = 1; d <= 4; d++) begin
      idx = last_q + 2'(d);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // Owner status relative to the rest of the requesters.
  always_comb begin
    owner_req  = req[last_q];
    others_req = |(req & ~(4'b0001 << last_q));
    hold_max   = (hold_q == CNT_W'(MAX_HOLD));
  end

  // Next-state and next-grant decision.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    s_d     = S;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          state_d = GRANT;
          last_d  = win;
          s_d     = win;
          gnt_d   = 4'b0001 << win;
          hold_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (|req) begin
            last_d = win;
            s_d    = win;
            gnt_d  = 4'b0001 << win;
            hold_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
          end
        end else if (hold_max && others_req) begin
          // Owner sits last in the scan, so another requester always wins here.
          last_d = win;
          s_d    = win;
          gnt_d  = 4'b0001 << win;
          hold_d = CNT_W'(1);
        end else if (hold_max) begin
          hold_d = CNT_W'(1);
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
  end

  // Arbitration state and registered grant/select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      hold_q  <= '0;
      gnt     <= 4'b0000;
      S       <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      S       <= s_d;
    end
  end

  // Capture the selected data bit during each grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y       <= 1'b0;
      Y_valid <= 1'b0;
    end else if (|gnt) begin
      Y       <= I[S];
      Y_valid <= 1'b1;
    end else begin
      Y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Bench for mux_4x1_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share stimulus and are compared against a behavioural owner/run model.
module tb_mux_4x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;

  logic [3:0] gnt0, gnt1;
  logic [1:0] s0, s1;
  logic       y0, y1, yv0, yv1;

  int checks = 0;
  int errors = 0;

  // Model state per instance: owner index (-1 idle), last winner, run length.
  int         m_owner [2];
  int         m_last  [2];
  int         m_run   [2];
  int         m_max   [2];
  logic [1:0] m_s     [2];
  logic       m_y     [2];
  logic       m_yv    [2];

  mux_4x1_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .I(din),
    .gnt(gnt0), .S(s0), .Y(y0), .Y_valid(yv0)
  );

  mux_4x1_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .I(din),
    .gnt(gnt1), .S(s1), .Y(y1), .Y_valid(yv1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic int pick(input int base, input logic [3:0] r);
    for (int d = 1; d <= 4; d++) begin
      if (r[(base + d) % 4]) return (base + d) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int o);
    logic [3:0] v;
    v = 4'b0000;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 3;
      m_run[k]   = 0;
      m_s[k]     = 2'b00;
      m_y[k]     = 1'b0;
      m_yv[k]    = 1'b0;
    end
  endtask

  // One clock of the reference behaviour, using inputs present before the edge.
  task automatic model_step(input int k, input logic [3:0] r, input logic [3:0] d);
    bit others;
    int o;
    int w;
    o = m_owner[k];
    if (o >= 0) begin
      m_y[k]  = d[o];
      m_yv[k] = 1'b1;
    end else begin
      m_yv[k] = 1'b0;
    end
    others = 1'b0;
    for (int j = 0; j < 4; j++) if (j != o && r[j]) others = 1'b1;
    w = pick(m_last[k], r);
    if (o < 0 || !r[o] || (m_run[k] == m_max[k] && others)) begin
      if (w >= 0) begin
        m_owner[k] = w;
        m_last[k]  = w;
        m_s[k]     = 2'(w);
        m_run[k]   = 1;
      end else begin
        m_owner[k] = -1;
      end
    end else if (m_run[k] == m_max[k]) begin
      m_run[k] = 1;
    end else begin
      m_run[k] = m_run[k] + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_gnt0"}, gnt0, onehot(m_owner[0]));
    chk({tag, "_s0"},   4'(s0),  4'(m_s[0]));
    chk({tag, "_y0"},   4'(y0),  4'(m_y[0]));
    chk({tag, "_yv0"},  4'(yv0), 4'(m_yv[0]));
    chk({tag, "_gnt1"}, gnt1, onehot(m_owner[1]));
    chk({tag, "_s1"},   4'(s1),  4'(m_s[1]));
    chk({tag, "_y1"},   4'(y1),  4'(m_y[1]));
    chk({tag, "_yv1"},  4'(yv1), 4'(m_yv[1]));
  endtask

  task automatic cyc(input string tag);
    model_step(0, req, din);
    model_step(1, req, din);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_max[0] = 4;
    m_max[1] = 1;
    model_reset();
    #2;
    do_reset();

    // Single requester, then release.
    din = 4'b0110;
    req = 4'b0001;
    cyc("t1");
    chk("t1_first_gnt", gnt0, 4'b0001);
    cyc("t1");
    chk("t1_yv", 4'(yv0), 4'd1);
    cyc("t1");
    req = 4'b0000;
    cyc("t1_drop");
    chk("t1_idle_gnt", gnt0, 4'b0000);
    cyc("t1_drop");
    chk("t1_idle_yv", 4'(yv0), 4'd0);

    // All requesting: bursts of MAX_HOLD cycles in rotation.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cyc("t2");
      chk("t2_owner", gnt0, onehot((i / 4) % 4));
    end

    // Owner drops; switch with no idle bubble.
    do_reset();
    req = 4'b0101;
    cyc("t3");
    cyc("t3");
    req = 4'b0100;
    cyc("t3_sw");
    chk("t3_sw_gnt", gnt0, 4'b0100);
    cyc("t3_y");
    chk("t3_y", 4'(y0), 4'd1);

    // Lone requester keeps ownership across hold reloads.
    do_reset();
    req = 4'b1000;
    din = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      cyc("t4");
      chk("t4_gnt", gnt0, 4'b1000);
    end

    // Asynchronous reset mid-burst.
    do_reset();
    req = 4'b1111;
    din = 4'b0110;
    for (int i = 0; i < 11; i++) cyc("t5");
    chk("t5_pre_owner", gnt0, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("t5_async");
    chk("t5_async_gnt", gnt0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5_post");
    chk("t5_post_gnt", gnt0, 4'b0001);

    // MAX_HOLD=1 alternation on the second instance.
    do_reset();
    req = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      cyc("t6");
      chk("t6_gnt1", gnt1, (i % 2 == 0) ? 4'b0010 : 4'b0100);
    end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din = 4'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the 4:1 bit multiplexer between four requesters. It grants one requester at a time and drives the mux select from the winning index. It also registers the selected data bit with a valid flag for the downstream consumer. A burst limit (MAX_HOLD) bounds how long one requester may keep ownership while others wait.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles for one owner while any other request is pending (legal range 1..15)
CNT_W, 4, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i, level-sensitive
I  input  4  mux data inputs; I[i] belongs to requester i
gnt  output  4  one-hot registered grant, all-zero when idle
S  output  2  registered mux select = index of current/last owner
Y  output  1  registered data bit, I[S] sampled during grant cycle
Y_valid  output  1  high one cycle after every cycle with gnt != 0

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values, applied immediately on rst_n low and also mid-operation: gnt=4'b0000, S=2'b00, Y=0, Y_valid=0, state=IDLE, last=2'd3 (requester 0 has first priority), hold_cnt=0.
- Priority search: scan indices last+1, last+2, last+3, last+4 (mod 4); the first asserted req wins. "last" updates to the winner on every new grant.
- State IDLE, gnt=0:
  - any req high at an edge -> GRANT next cycle with winner's gnt bit set, S=winner, hold_cnt=1.
  - Latency from req to gnt is exactly 1 clock.
- State GRANT, owner o. Each edge evaluates, in order:
  1. req[o] low: if another req is high, switch directly to the next winner (no idle bubble), hold_cnt=1. Otherwise go to IDLE with gnt=0; S keeps o.
  2. req[o] high and hold_cnt==MAX_HOLD and another req high: forced rotate to the next winner, searched from o+1. The owner is eligible again only after the others in rotation.
  3. req[o] high and hold_cnt==MAX_HOLD and no other req: owner retains, hold_cnt reloads to 1.
  4. Otherwise retain, hold_cnt+1.
- gnt is always zero or one-hot; S always equals the index of the set gnt bit when gnt != 0.
- Datapath: at each edge where gnt != 0, Y<=I[S] and Y_valid<=1. Otherwise Y holds and Y_valid<=0. Y therefore lags its grant cycle by one clock.
- MAX_HOLD=1: contending requesters rotate every cycle.
- Simultaneous req assert/deassert by different requesters in one cycle: resolve using the values sampled at that edge only.
- Req toggling while not owner: no effect until the next arbitration point.
- I changes are not arbitrated; I[S] is sampled as-is.

Test Plan:
1. Reset, then req=4'b0001, I=4'b0110 for 3 cycles -> gnt=0001 one cycle after req, S=00; Y=0, Y_valid=1 from the following cycle; req=0 -> gnt=0000 next cycle, Y_valid=0 one cycle later.
2. req=4'b1111 held, MAX_HOLD=4, I=4'b0110 -> owner sequence 0,1,2,3,0 with each held exactly 4 cycles; Y sequence 0,1,1,0 per burst.
3. req=4'b0101, owner 0 drops req after 2 cycles -> gnt switches 0001->0100 on the next edge with no zero cycle; S=10, Y=1.
4. Single requester req=4'b1000 held 10 cycles, MAX_HOLD=4 -> gnt=1000 continuously, no drop at hold_cnt reload; S=11, Y=I[3].
5. rst_n pulsed low mid-burst (owner 2, hold_cnt=3) -> gnt, Y, Y_valid zero immediately (asynchronous, before the next edge); after release with req=4'b1111 the first grant goes to requester 0.
6. MAX_HOLD=1, req=4'b0110 -> gnt alternates 0010, 0100 every cycle; S alternates 01, 10; Y_valid stays 1.
